// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the pipeline memory stage       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

    localparam int DEFAULT_WAIT_LIMIT = 16;

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_align : byte-lane steering for stores and zero-extending byte loads  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_align
    import mem_pkg::*;
(
    input  logic        byte_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (byte_i) begin
            be_o    = BE_BYTE0 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
            case (offset_i)
                2'd0:    rdata_o = {24'h0, rdata_i[7:0]};
                2'd1:    rdata_o = {24'h0, rdata_i[15:8]};
                2'd2:    rdata_o = {24'h0, rdata_i[23:16]};
                default: rdata_o = {24'h0, rdata_i[31:24]};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage : pipeline memory stage with variable-latency data handshake   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_stage
    import mem_pkg::*;
#(
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   ALUResultE,
    input  logic          ByteE,
    input  logic          PCSrcM,
    input  logic          RegWriteM,
    input  logic          MemtoRegM,
    input  logic          MemWriteM,
    input  logic [31:0]   WriteDataM,
    input  logic [3:0]    WriteAddrM,
    output logic [31:0]   ALUResultM,
    output logic          StallM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready,
    output logic          PCSrcW,
    output logic          RegWriteW,
    output logic          MemtoRegW,
    output logic [31:0]   ReadDataW,
    output logic [31:0]   ALUOutW,
    output logic [3:0]    WriteAddrW,
    output logic          MemFaultW
);

    localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      alu_result_q;
    logic             byte_q;
    logic             pcsrc_w_q, regwrite_w_q, memtoreg_w_q, fault_w_q;
    logic [31:0]      rdata_w_q, aluout_w_q;
    logic [3:0]       waddr_w_q;

    logic             w_acc, w_aligned, w_req, w_stall, w_abort, w_fault;
    logic [31:0]      w_rdata_al;

    assign w_acc     = MemWriteM | MemtoRegM;
    assign w_aligned = byte_q | (alu_result_q[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_req   = 1'b0;
        w_stall = 1'b0;
        w_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_acc && w_aligned) begin
                    w_req = 1'b1;
                    if (!mem_ready) begin
                        w_stall = 1'b1;
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                w_req = 1'b1;
                // Completion takes priority over hitting the limit in the same cycle.
                if (mem_ready) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(WAIT_LIMIT)) begin
                    w_abort = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    w_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_fault = (w_acc & ~w_aligned) | w_abort;

    mem_align u_align (
        .byte_i   (byte_q),
        .offset_i (alu_result_q[1:0]),
        .wdata_i  (WriteDataM),
        .rdata_i  (mem_rdata),
        .be_o     (mem_be),
        .wdata_o  (mem_wdata),
        .rdata_o  (w_rdata_al)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_result_q <= '0;
            byte_q       <= 1'b0;
            pcsrc_w_q    <= 1'b0;
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
            fault_w_q    <= 1'b0;
            rdata_w_q    <= '0;
            aluout_w_q   <= '0;
            waddr_w_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_stall) begin
                pcsrc_w_q    <= 1'b0;
                regwrite_w_q <= 1'b0;
                memtoreg_w_q <= 1'b0;
                fault_w_q    <= 1'b0;
            end else begin
                alu_result_q <= ALUResultE;
                byte_q       <= ByteE;
                pcsrc_w_q    <= PCSrcM;
                regwrite_w_q <= RegWriteM & ~w_fault;
                memtoreg_w_q <= MemtoRegM;
                fault_w_q    <= w_fault;
                rdata_w_q    <= w_rdata_al;
                aluout_w_q   <= alu_result_q;
                waddr_w_q    <= WriteAddrM;
            end
        end
    end

    // Handshake and stall are suppressed for the whole time reset is held.
    assign mem_req    = w_req & reset;
    assign StallM     = w_stall & reset;
    assign mem_we     = mem_req & MemWriteM;
    assign mem_addr   = {alu_result_q[AW-1:2], 2'b00};
    assign ALUResultM = alu_result_q;

    assign PCSrcW     = pcsrc_w_q;
    assign RegWriteW  = regwrite_w_q;
    assign MemtoRegW  = memtoreg_w_q;
    assign MemFaultW  = fault_w_q;
    assign ReadDataW  = rdata_w_q;
    assign ALUOutW    = aluout_w_q;
    assign WriteAddrW = waddr_w_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage : scoreboard bench for the memory stage (WAIT_LIMIT = 4)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

    localparam int TB_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultE;
    logic        ByteE;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] WriteDataM;
    logic [3:0]  WriteAddrM;
    logic [31:0] ALUResultM;
    logic        StallM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        PCSrcW, RegWriteW, MemtoRegW, MemFaultW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [3:0]  WriteAddrW;

    typedef struct {
        logic        pcsrc;
        logic        rw;
        logic        m2r;
        logic        fault;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [3:0]  wa;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    mem_stage #(.WAIT_LIMIT(TB_LIMIT), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .ALUResultE(ALUResultE), .ByteE(ByteE),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .WriteDataM(WriteDataM), .WriteAddrM(WriteAddrM),
        .ALUResultM(ALUResultM), .StallM(StallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteAddrW(WriteAddrW),
        .MemFaultW(MemFaultW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic push(input logic pcs, input logic rw, input logic m2r, input logic flt,
                        input logic [31:0] alu, input logic [31:0] rd, input logic [3:0] wa);
        exp_t e;
        e.pcsrc = pcs; e.rw = rw; e.m2r = m2r; e.fault = flt;
        e.alu = alu; e.rd = rd; e.wa = wa;
        sb_q.push_back(e);
    endtask

    task automatic clear_m();
        PCSrcM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
        WriteDataM = 32'h0; WriteAddrM = 4'h0;
    endtask

    // Any W cycle with a control bit set is a retiring instruction.
    always @(negedge clk) begin
        if (reset === 1'b1 && (PCSrcW | RegWriteW | MemtoRegW | MemFaultW)) begin
            if (sb_q.size() == 0) begin
                chk("spurious_retire", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("w_pcsrc", {31'h0, PCSrcW}, {31'h0, mon_e.pcsrc});
                chk("w_regwrite", {31'h0, RegWriteW}, {31'h0, mon_e.rw});
                chk("w_fault", {31'h0, MemFaultW}, {31'h0, mon_e.fault});
                chk("w_aluout", ALUOutW, mon_e.alu);
                chk("w_waddr", {28'h0, WriteAddrW}, {28'h0, mon_e.wa});
                if (!mon_e.fault) chk("w_memtoreg", {31'h0, MemtoRegW}, {31'h0, mon_e.m2r});
                if (mon_e.m2r && !mon_e.fault) chk("w_rdata", ReadDataW, mon_e.rd);
            end
        end
    end

    // One instruction through M; the bench plays the execute register and the memory.
    task automatic do_access(input logic [31:0] addr, input logic byt, input logic pcs,
                             input logic rw, input logic m2r, input logic mw,
                             input logic [31:0] wd, input logic [3:0] wa,
                             input logic [31:0] rd, input int rdy_after,
                             output int stalls, output logic req0, output logic we0,
                             output logic [3:0] be0, output logic [31:0] wdata0,
                             output logic [31:0] addr0);
        bit done = 0;
        stalls = 0; req0 = 0; we0 = 0; be0 = 0; wdata0 = 0; addr0 = 0;
        @(negedge clk);
        ALUResultE = addr; ByteE = byt;
        @(posedge clk); #1;
        PCSrcM = pcs; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
        WriteDataM = wd; WriteAddrM = wa;
        ALUResultE = 32'hFFFF_FFF0; ByteE = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            mem_ready = (rdy_after >= 0 && cyc >= rdy_after);
            mem_rdata = mem_ready ? rd : 32'hBAD0_BAD0;
            @(negedge clk);
            if (cyc == 0) begin
                req0 = mem_req; we0 = mem_we; be0 = mem_be; wdata0 = mem_wdata; addr0 = mem_addr;
            end else begin
                chk("addr_hold", mem_addr, addr0);
                chk("w_bubble", {29'h0, RegWriteW, MemtoRegW, MemFaultW}, 32'h0);
            end
            if (StallM) stalls++;
            else done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        clear_m();
        mem_ready = 1'b0;
    endtask

    initial begin
        int          st;
        logic        rq, we;
        logic [3:0]  be;
        logic [31:0] wdt, ad;

        reset = 1'b0; ALUResultE = 32'h40; ByteE = 1'b0;
        clear_m(); MemtoRegM = 1'b1;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_aluresm", ALUResultM, 32'h0);
        chk("rst_stall", {31'h0, StallM}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_w", {28'h0, RegWriteW, MemtoRegW, MemFaultW, PCSrcW}, 32'h0);
        chk("rst_w_data", ReadDataW | ALUOutW, 32'h0);
        clear_m();
        reset = 1'b1;

        // Plain ALU op with a branch flag
        push(1, 1, 0, 0, 32'h0000_1234, 32'h0, 4'h3);
        do_access(32'h0000_1234, 0, 1, 1, 0, 0, 32'h0, 4'h3, 32'h0, -1, st, rq, we, be, wdt, ad);
        chk("alu_stall", st, 0);
        chk("alu_req", {31'h0, rq}, 32'h0);

        // Zero-wait word load
        push(0, 1, 1, 0, 32'h0000_0100, 32'hDEAD_BEEF, 4'h5);
        do_access(32'h0000_0100, 0, 0, 1, 1, 0, 32'h0, 4'h5, 32'hDEAD_BEEF, 0, st, rq, we, be, wdt, ad);
        chk("ldw0_stall", st, 0);
        chk("ldw0_req", {31'h0, rq}, 32'h1);
        chk("ldw0_be", {28'h0, be}, 32'hF);
        chk("ldw0_addr", ad, 32'h0000_0100);

        // Byte store to lane 3
        do_access(32'h0000_0203, 1, 0, 0, 0, 1, 32'h0000_00A5, 4'h0, 32'h0, 0, st, rq, we, be, wdt, ad);
        chk("stb_be", {28'h0, be}, 32'h8);
        chk("stb_wdata", wdt, 32'hA5A5_A5A5);
        chk("stb_we", {31'h0, we}, 32'h1);
        chk("stb_addr", ad, 32'h0000_0200);
        chk("stb_stall", st, 0);

        // Word store with two wait cycles
        do_access(32'h0000_0208, 0, 0, 0, 0, 1, 32'h1234_5678, 4'h0, 32'h0, 2, st, rq, we, be, wdt, ad);
        chk("stw_stall", st, 2);
        chk("stw_be", {28'h0, be}, 32'hF);
        chk("stw_wdata", wdt, 32'h1234_5678);
        chk("stw_we", {31'h0, we}, 32'h1);

        // Byte load from lane 2
        push(0, 1, 1, 0, 32'h0000_0102, 32'h0000_0022, 4'h7);
        do_access(32'h0000_0102, 1, 0, 1, 1, 0, 32'h0, 4'h7, 32'h1122_3344, 0, st, rq, we, be, wdt, ad);
        chk("ldb_be", {28'h0, be}, 32'h4);
        chk("ldb_we", {31'h0, we}, 32'h0);

        // Load completing three cycles after the request
        push(0, 1, 1, 0, 32'h0000_0300, 32'hCAFE_F00D, 4'h9);
        do_access(32'h0000_0300, 0, 0, 1, 1, 0, 32'h0, 4'h9, 32'hCAFE_F00D, 3, st, rq, we, be, wdt, ad);
        chk("ldw3_stall", st, 3);

        // Never-ready load aborts at the wait limit
        push(0, 0, 1, 1, 32'h0000_0400, 32'h0, 4'hA);
        do_access(32'h0000_0400, 0, 0, 1, 1, 0, 32'h0, 4'hA, 32'h0, -1, st, rq, we, be, wdt, ad);
        chk("tmo_stall", st, TB_LIMIT + 1);
        chk("tmo_req", {31'h0, rq}, 32'h1);

        // Misaligned word load
        push(0, 0, 1, 1, 32'h0000_0101, 32'h0, 4'hB);
        do_access(32'h0000_0101, 0, 0, 1, 1, 0, 32'h0, 4'hB, 32'h0, 0, st, rq, we, be, wdt, ad);
        chk("mis_req", {31'h0, rq}, 32'h0);
        chk("mis_stall", st, 0);

        // Reset during the second wait cycle
        @(negedge clk);
        ALUResultE = 32'h0000_0600;
        @(posedge clk); #1;
        RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteAddrM = 4'hC; ALUResultE = 32'h0;
        mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rstw_stall_pre", {31'h0, StallM}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rstw_req", {31'h0, mem_req}, 32'h0);
        chk("rstw_stall", {31'h0, StallM}, 32'h0);
        chk("rstw_w", {28'h0, RegWriteW, MemtoRegW, MemFaultW, PCSrcW}, 32'h0);
        chk("rstw_w_data", ReadDataW | ALUOutW | {28'h0, WriteAddrW}, 32'h0);
        clear_m();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Access after reset proceeds from IDLE
        push(0, 1, 1, 0, 32'h0000_0500, 32'h5555_AAAA, 4'hD);
        do_access(32'h0000_0500, 0, 0, 1, 1, 0, 32'h0, 4'hD, 32'h5555_AAAA, 1, st, rq, we, be, wdt, ad);
        chk("post_stall", st, 1);
        chk("post_addr", ad, 32'h0000_0500);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage ARM pipeline, directly downstream of the execute stage.
- Registers the unregistered execute-stage ALU result, performs loads and stores over a variable-latency data-memory handshake, and stalls the front of the pipe while an access is outstanding.
- Produces the M/W pipeline register.
- Returns ALUResultM to execute for forwarding.

Parameters:
- WAIT_LIMIT, 16: maximum wait cycles after the request cycle before an access is aborted as a fault.
- AW, 32: data-memory address width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- ALUResultE  in  32  execute ALU result (unregistered in execute)
- ByteE  in  1  byte access (LDRB/STRB), aligned with ALUResultE
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  in  1 each  control bits, already registered by execute
- WriteDataM  in  32  store data
- WriteAddrM  in  4  destination register
- ALUResultM  out  32  registered address/result; also the forwarding source
- StallM  out  1  holds F/D/E registers and this stage's input register
- mem_req  out  1  access request
- mem_we  out  1  write enable
- mem_addr  out  AW  word-aligned address ({ALUResultM[AW-1:2],2'b00})
- mem_wdata  out  32  store data, lane-aligned
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data, valid when mem_ready
- mem_ready  in  1  completes the current request
- PCSrcW, RegWriteW, MemtoRegW  out  1 each  writeback control
- ReadDataW  out  32  aligned load data
- ALUOutW  out  32
- WriteAddrW  out  4
- MemFaultW  out  1  one-cycle pulse with the faulting instruction in W

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs are 0; FSM is in IDLE; wait counter is 0.
  - mem_req=0 and StallM=0 while reset is asserted.
  - Reset during WAIT abandons the access; no write-back results.
- Input register: ALUResultM and ByteM load from ALUResultE and ByteE on posedge when StallM=0, and hold when StallM=1.
- Access condition: acc = MemWriteM | MemtoRegM.
- Misalignment: a word access with ALUResultM[1:0]!=0 is misaligned. It issues no request, never stalls, and retires with RegWriteW=0 and MemFaultW=1.
- Byte store:
  - mem_be = 4'b0001 << ALUResultM[1:0].
  - mem_wdata = byte replicated on all four lanes.
- Word store: mem_be = 4'hF and mem_wdata = WriteDataM.
- Loads: mem_be follows the same rule as stores. A byte load zero-extends the addressed lane.
- FSM states are IDLE and WAIT.
  - IDLE: mem_req = acc & aligned, driven combinationally in the first cycle.
    - mem_ready=1 in the same cycle: zero-wait completion; StallM=0; stay in IDLE.
    - Otherwise: StallM=1; go to WAIT; wait counter = 0.
  - WAIT: mem_req=1. mem_addr, mem_we, mem_be and mem_wdata are held stable.
    - mem_ready=1: complete; StallM=0; go to IDLE.
    - Counter reaches WAIT_LIMIT: abort; StallM=0; go to IDLE; retire with RegWriteW=0 and MemFaultW=1.
    - Otherwise: increment the counter; StallM=1.
  - mem_ready is ignored when mem_req=0.
- M/W register: each posedge loads PCSrc, RegWrite, MemtoReg, ALUOut, WriteAddr, ReadData and MemFault from M.
  - While StallM=1, W loads a bubble: all control bits 0 and data unchanged.
- Latency: a non-memory instruction reaches W one cycle after M. A load with n wait cycles reaches W after n+1 cycles.
- Simultaneous mem_ready and counter limit in the same cycle: completion wins.

Decomposition:
- Shared package mem_pkg holds:
  - mem_state_t enum {IDLE, WAIT}
  - BE_WORD = 4'hF
  - BE_BYTE0 = 4'b0001
  - the default WAIT_LIMIT
- One sub-module, mem_align (combinational), derives mem_be, mem_wdata and the aligned load data from byte, offset, store data and raw read data.
- The FSM and the pipeline registers remain in mem_stage.

Test Plan:
- Zero-wait word load: ALUResultE=0x100, MemtoRegM=1, mem_rdata=0xDEADBEEF, mem_ready=1 in the first cycle.
  - Expect StallM never asserts; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
- Byte store: ALUResultM=0x203, WriteDataM=0x000000A5.
  - Expect mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1.
- Byte load: lane 2 of 0x11223344 at address 0x102.
  - Expect ReadDataW=0x00000022.
- Multi-cycle load: mem_ready rises 3 cycles after the request.
  - Expect StallM=1 for 3 cycles with address stable, W bubbles (RegWriteW=0) for 3 cycles, then the load retires.
- Timeout: mem_ready held 0 with WAIT_LIMIT=4.
  - Expect abort after the counter reaches the limit, MemFaultW=1 for one cycle, RegWriteW=0.
  - Separately: misaligned word access at 0x101 gives mem_req=0 and MemFaultW=1.
- Reset mid-WAIT: reset=0 during the second wait cycle.
  - Expect mem_req, StallM and all W outputs 0 immediately; after release, FSM is in IDLE and the next access proceeds normally.
